// File: rtl/call_sequencer.sv
// Subroutine call/return sequencer: pushes the return PC onto a descending stack,
// fetches the two-byte target (or pops the saved PC) and steers the PC cache unit.
module call_sequencer (
    input  logic       clk,
    input  logic       reset,
    input  logic       call_req,
    input  logic       ret_req,
    input  logic [7:0] target_addr,
    input  logic       dec_cache_write,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       cache_write,
    output logic       loader_select,
    output logic [7:0] mem_addr,
    output logic       mem_read,
    output logic       mem_write,
    output logic       pc_load,
    output logic [7:0] sp
);

    localparam logic [7:0] SP_INIT     = 8'd255;
    localparam logic [7:0] SP_MIN      = 8'd192;
    localparam logic [7:0] SP_CALL_MIN = SP_MIN + 8'd1;   // a push needs two free bytes
    localparam logic [7:0] SP_RET_MAX  = SP_INIT - 8'd2;  // a pop needs two stacked bytes

    typedef enum logic [2:0] {IDLE, PUSH_HI, PUSH_LO, RD0, RD1, LOAD} state_t;

    state_t     state_q, state_d;
    logic [7:0] sp_q, sp_d;
    logic [7:0] addr_q, addr_d;
    logic       fault_q, fault_d;
    logic       is_ret_q, is_ret_d;

    // NOTE: state registers use non-blocking assignments and reset asynchronously.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            sp_q     <= SP_INIT;
            addr_q   <= 8'd0;
            fault_q  <= 1'b0;
            is_ret_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            sp_q     <= sp_d;
            addr_q   <= addr_d;
            fault_q  <= fault_d;
            is_ret_q <= is_ret_d;
        end
    end

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d       = state_q;
        sp_d          = sp_q;
        addr_d        = addr_q;
        fault_d       = fault_q;
        is_ret_d      = is_ret_q;
        busy          = 1'b1;
        done          = 1'b0;
        cache_write   = 1'b0;
        loader_select = 1'b1;
        mem_addr      = 8'd0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        pc_load       = 1'b0;

        case (state_q)
            IDLE: begin
                busy        = 1'b0;
                cache_write = dec_cache_write;
                if (!fault_q) begin
                    if (call_req) begin
                        if (sp_q < SP_CALL_MIN) begin
                            fault_d = 1'b1;
                        end else begin
                            cache_write = 1'b1;
                            addr_d      = target_addr;
                            is_ret_d    = 1'b0;
                            state_d     = PUSH_HI;
                        end
                    end else if (ret_req) begin
                        if (sp_q > SP_RET_MAX) begin
                            fault_d = 1'b1;
                        end else begin
                            addr_d   = sp_q + 8'd1;
                            is_ret_d = 1'b1;
                            state_d  = RD0;
                        end
                    end
                end
            end
            PUSH_HI: begin
                mem_write     = 1'b1;
                mem_addr      = sp_q;
                loader_select = 1'b0;
                sp_d          = sp_q - 8'd1;
                state_d       = PUSH_LO;
            end
            PUSH_LO: begin
                mem_write = 1'b1;
                mem_addr  = sp_q;
                sp_d      = sp_q - 8'd1;
                state_d   = RD0;
            end
            RD0: begin
                mem_read = 1'b1;
                mem_addr = addr_q;
                state_d  = RD1;
            end
            RD1: begin
                // Upper register captures the byte read at addr while addr+1 is requested.
                mem_read      = 1'b1;
                mem_addr      = addr_q + 8'd1;
                loader_select = 1'b0;
                state_d       = LOAD;
            end
            LOAD: begin
                pc_load = 1'b1;
                done    = 1'b1;
                if (is_ret_q) sp_d = sp_q + 8'd2;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Decoder write requests must not reach the cache unit while held in reset.
        if (!reset) cache_write = 1'b0;
    end

    assign fault = fault_q;
    assign sp    = sp_q;

endmodule

// File: tb/tb_call_sequencer.sv
// Self-checking bench for call_sequencer: per-cycle vector table plus a memory/PC-load
// transaction scoreboard for nested calls, overflow/underflow and mid-sequence reset.
module tb_call_sequencer;

    logic       clk;
    logic       reset;
    logic       call_req, ret_req, dec_cache_write;
    logic [7:0] target_addr;
    logic       busy, done, fault, cache_write, loader_select;
    logic [7:0] mem_addr, sp;
    logic       mem_read, mem_write, pc_load;

    call_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .call_req       (call_req),
        .ret_req        (ret_req),
        .target_addr    (target_addr),
        .dec_cache_write(dec_cache_write),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .cache_write    (cache_write),
        .loader_select  (loader_select),
        .mem_addr       (mem_addr),
        .mem_read       (mem_read),
        .mem_write      (mem_write),
        .pc_load        (pc_load),
        .sp             (sp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] K_WR = 2'd1, K_RD = 2'd2, K_LD = 2'd3;

    typedef struct {
        logic [1:0] kind;
        logic [7:0] addr;
    } txn_t;

    typedef struct {
        logic       call;
        logic       ret;
        logic       dcw;
        logic [7:0] tgt;
        logic [6:0] flags;  // {busy,done,cache_write,loader_select,mem_read,mem_write,pc_load}
        logic [7:0] addr;
        logic [7:0] sp;
    } vec_t;

    txn_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    logic [7:0] m_sp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_txn(input logic [1:0] k, input logic [7:0] a);
        txn_t t;
        t.kind = k;
        t.addr = a;
        exp_q.push_back(t);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: every strobe observed must match the next expected transaction.
    always @(negedge clk) begin
        if (reset && (mem_read || mem_write || pc_load)) begin
            txn_t a, e;
            a.kind = mem_write ? K_WR : (mem_read ? K_RD : K_LD);
            a.addr = pc_load ? 8'd0 : mem_addr;
            if (exp_q.size() == 0) begin
                check("unexpected_txn", {22'd0, a.kind, a.addr}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("txn_kind", {30'd0, a.kind}, {30'd0, e.kind});
                check("txn_addr", {24'd0, a.addr}, {24'd0, e.addr});
            end
        end
    end

    // Runs one accepted call or return, checking latency and the resulting stack pointer.
    task automatic run_seq(input logic is_call, input logic [7:0] tgt);
        int cnt;
        if (is_call) begin
            push_txn(K_WR, m_sp);
            push_txn(K_WR, m_sp - 8'd1);
            push_txn(K_RD, tgt);
            push_txn(K_RD, tgt + 8'd1);
            push_txn(K_LD, 8'd0);
            call_req = 1'b1;
        end else begin
            push_txn(K_RD, m_sp + 8'd1);
            push_txn(K_RD, m_sp + 8'd2);
            push_txn(K_LD, 8'd0);
            ret_req = 1'b1;
        end
        target_addr = tgt;
        step();
        call_req = 1'b0;
        ret_req  = 1'b0;
        cnt = 1;
        while (!done && cnt < 12) begin
            step();
            cnt++;
        end
        check(is_call ? "call_latency" : "ret_latency", cnt, is_call ? 5 : 3);
        step();
        m_sp = is_call ? m_sp - 8'd2 : m_sp + 8'd2;
        check("seq_sp", {24'd0, sp}, {24'd0, m_sp});
        check("seq_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        dec_cache_write = 1'b1;
        #1;
        check("rst_sp", {24'd0, sp}, 32'd255);
        check("rst_flags", {25'd0, busy, done, fault, cache_write, mem_read, mem_write, pc_load}, 32'd0);
        check("rst_ls_addr", {23'd0, loader_select, mem_addr}, 32'h100);
        dec_cache_write = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        m_sp = 8'd255;
    endtask

    vec_t vecs[11];

    initial begin
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h10, 7'b0011000, 8'd0,   8'd255};
        vecs[1]  = '{1'b0, 1'b0, 1'b1, 8'h00, 7'b1000010, 8'd255, 8'd255};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1001010, 8'd254, 8'd254};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1001100, 8'h10,  8'd253};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1000100, 8'h11,  8'd253};
        vecs[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1101001, 8'd0,   8'd253};
        vecs[6]  = '{1'b0, 1'b1, 1'b0, 8'h00, 7'b0001000, 8'd0,   8'd253};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1001100, 8'd254, 8'd253};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1000100, 8'd255, 8'd253};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 8'h00, 7'b1101001, 8'd0,   8'd253};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 8'h00, 7'b0011000, 8'd0,   8'd255};

        reset = 1'b0;
        call_req = 1'b0;
        ret_req = 1'b0;
        dec_cache_write = 1'b0;
        target_addr = 8'd0;
        m_sp = 8'd255;
        repeat (2) @(posedge clk);
        do_reset();

        // Call to 0x10 then return, first request right after reset release.
        push_txn(K_WR, 8'd255);
        push_txn(K_WR, 8'd254);
        push_txn(K_RD, 8'h10);
        push_txn(K_RD, 8'h11);
        push_txn(K_LD, 8'd0);
        push_txn(K_RD, 8'd254);
        push_txn(K_RD, 8'd255);
        push_txn(K_LD, 8'd0);
        for (int i = 0; i < 11; i++) begin
            call_req        = vecs[i].call;
            ret_req         = vecs[i].ret;
            dec_cache_write = vecs[i].dcw;
            target_addr     = vecs[i].tgt;
            #1;
            check($sformatf("vec%0d_flags", i),
                  {25'd0, busy, done, cache_write, loader_select, mem_read, mem_write, pc_load},
                  {25'd0, vecs[i].flags});
            check($sformatf("vec%0d_addr", i), {24'd0, mem_addr}, {24'd0, vecs[i].addr});
            check($sformatf("vec%0d_sp", i), {24'd0, sp}, {24'd0, vecs[i].sp});
            step();
        end
        call_req = 1'b0;
        ret_req = 1'b0;
        dec_cache_write = 1'b0;
        m_sp = 8'd255;

        // Simultaneous call and ret: call wins.
        ret_req = 1'b1;
        run_seq(1'b1, 8'h20);
        run_seq(1'b0, 8'h00);

        // 32 nested calls fill the stack exactly, the 33rd overflows.
        for (int i = 0; i < 32; i++) run_seq(1'b1, 8'(i * 3));
        check("nested_sp", {24'd0, sp}, 32'd191);
        call_req = 1'b1;
        step();
        call_req = 1'b0;
        check("ovf_fault", {31'd0, fault}, 32'd1);
        check("ovf_busy", {31'd0, busy}, 32'd0);
        check("ovf_sp", {24'd0, sp}, 32'd191);
        ret_req = 1'b1;
        step();
        step();
        ret_req = 1'b0;
        check("ovf_ret_ignored", {31'd0, busy}, 32'd0);
        check("ovf_sticky", {31'd0, fault}, 32'd1);

        // Underflow on an empty stack, then a call is ignored until reset.
        do_reset();
        ret_req = 1'b1;
        step();
        ret_req = 1'b0;
        check("udf_fault", {31'd0, fault}, 32'd1);
        check("udf_sp", {24'd0, sp}, 32'd255);
        call_req = 1'b1;
        step();
        step();
        call_req = 1'b0;
        check("udf_call_ignored", {31'd0, busy}, 32'd0);
        check("udf_call_sp", {24'd0, sp}, 32'd255);

        // Reset asserted while in RD1 aborts the sequence.
        do_reset();
        push_txn(K_WR, 8'd255);
        push_txn(K_WR, 8'd254);
        push_txn(K_RD, 8'h40);
        push_txn(K_RD, 8'h41);
        call_req = 1'b1;
        target_addr = 8'h40;
        step();
        call_req = 1'b0;
        repeat (3) step();
        check("rd1_state", {22'd0, mem_read, loader_select, mem_addr}, {22'd0, 1'b1, 1'b0, 8'h41});
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_sp", {24'd0, sp}, 32'd255);
        check("abort_strobes", {29'd0, mem_read, mem_write, pc_load}, 32'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) step();
        check("abort_no_done", {31'd0, done}, 32'd0);
        check("queue_empty", exp_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/call_sequencer.md
CALL_SEQUENCER -- requirements
Module: call_sequencer

Interface
REQ-001 SP_INIT, 8'd255, stack pointer value after reset; top of stack region.
REQ-002 SP_MIN, 8'd192, lowest legal stack address; bottom of stack region.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset.
REQ-005 call_req  in  1  request: push return PC, then load PC from target_addr/target_addr+1.
REQ-006 ret_req  in  1  request: pop PC from stack.
REQ-007 target_addr  in  8  memory address of the two-byte call target; sampled at accept.
REQ-008 dec_cache_write  in  1  decoder's cache-unit write request.
REQ-009 busy  out  1  sequence in progress; requests ignored.
REQ-010 done  out  1  one-cycle pulse in the final (LOAD) cycle of a sequence.
REQ-011 fault  out  1  sticky stack overflow/underflow flag.
REQ-012 cache_write  out  1  drives the cache unit's cache_write.
REQ-013 loader_select  out  1  drives the cache unit's loader_select (0 = capture upper/save pc_upper, 1 = hold/save cached_lower).
REQ-014 mem_addr  out  8  data memory address.
REQ-015 mem_read  out  1  read strobe; data valid on mem_out the following cycle.
REQ-016 mem_write  out  1  write strobe; data is cache unit save_out.
REQ-017 pc_load  out  1  PC loads cache unit load_out this edge.
REQ-018 sp  out  8  current stack pointer.

Function
REQ-019 States SHALL be IDLE, PUSH_HI, PUSH_LO, RD0, RD1, LOAD; encoding free.
REQ-020 Requests SHALL be sampled only in IDLE with fault=0; call_req SHALL win when both asserted.
REQ-021 Requests while busy or fault=1 SHALL be ignored, not queued; requester holds until accepted.
REQ-022 Call accept cycle (IDLE): cache_write=1 (snapshot PC low into cache unit), latch target_addr into an internal address register; next state PUSH_HI.
REQ-023 PUSH_HI: mem_write=1, mem_addr=sp, loader_select=0; sp<=sp-1.
REQ-024 PUSH_LO: mem_write=1, mem_addr=sp, loader_select=1; sp<=sp-1; next RD0 with address register=target.
REQ-025 Ret accept cycle (IDLE): address register<=sp+1; next RD0; no cache_write.
REQ-026 RD0: mem_read=1, mem_addr=addr, loader_select=1; next RD1.
REQ-027 RD1: mem_read=1, mem_addr=addr+1 (8-bit wrap), loader_select=0 so upper register captures byte at addr; next LOAD.
REQ-028 LOAD: loader_select=1, pc_load=1, done=1; for ret, sp<=sp+2; next IDLE. Resulting PC = {mem[addr+1], mem[addr]}.
REQ-029 Call latency: accept edge to done = 5 cycles; ret: 3 cycles; busy=1 in every non-IDLE state.
REQ-030 Overflow: call accepted with sp < SP_MIN+1 SHALL set fault, issue no memory access, stay IDLE, no done.
REQ-031 Underflow: ret accepted with sp > SP_INIT-2 SHALL set fault likewise.
REQ-032 fault SHALL clear only on reset.
REQ-033 dec_cache_write SHALL forward to cache_write only in IDLE; in non-IDLE states it SHALL be dropped.
REQ-034 In IDLE, cache_write = dec_cache_write OR call-accept.
REQ-035 Outside states listed, mem_read=mem_write=pc_load=done=0, loader_select=1, mem_addr=0.
REQ-036 Address arithmetic SHALL be 8-bit modulo; sp never leaves [SP_MIN-1, SP_INIT] due to REQ-030/031.

Reset
REQ-037 reset low SHALL asynchronously force state=IDLE, sp=SP_INIT, fault=0, address register=0, and all strobes, busy, done=0, loader_select=1, mem_addr=0.
REQ-038 Reset mid-sequence SHALL abort with no further memory strobes; partial stack writes are not undone.
REQ-039 First request SHALL be accepted on the first rising edge after reset deasserts.

Verification
REQ-040 Call, sp=255, target_addr=0x10, mem[0x10]=0x34, mem[0x11]=0x12 -> writes to 255 (pc_upper), 254 (cached_lower), pc_load with load_out=0x1234, sp=253, done 5 cycles after accept.
REQ-041 Ret after REQ-040 -> reads 254, 255; load_out={pc_upper,pc_lower} of saved PC; sp=255, done 3 cycles after accept.
REQ-042 Ret with sp=255 -> fault=1, no mem_read, sp unchanged; later call_req ignored until reset.
REQ-043 32 nested calls from sp=255 -> sp=191; 33rd call at sp=191 faults, no writes below 192.
REQ-044 call_req and ret_req together in IDLE -> call sequence; dec_cache_write pulses during PUSH_HI absent from cache_write.
REQ-045 reset low during RD1 -> immediate IDLE, sp=255, busy=0, no pc_load.
